// File: rtl/decode_issue_queue.sv
// decode_issue_queue: in-order FIFO between fetch and the decoders, tagging each bundle with a major ID
// Ports: clock_i/reset_i (async active-low), flush_i; fetch side fetchValid_i/fetchReady_o plus bundle inputs;
//        decoder side stall_i/enable_o plus registered issued bundle, opcode, major ID; occupancy_o.
module decode_issue_queue #(
  parameter int addressWidth            = 64,
  parameter int instructionWidth        = 32,
  parameter int PidSize                 = 20,
  parameter int TidSize                 = 16,
  parameter int instructionCounterWidth = 64,
  parameter int PrimOpcodeSize          = 6,
  parameter int formatWidth             = 25,
  parameter int queueDepth              = 4,
  parameter int countWidth              = 3
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               fetchValid_i,
  output logic                               fetchReady_o,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic [formatWidth-1:0]             instFormat_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               stall_i,
  output logic                               enable_o,
  output logic [formatWidth-1:0]             instFormat_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [PrimOpcodeSize-1:0]          instructionOpcode_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o,
  output logic [countWidth-1:0]              occupancy_o
);
  localparam int PW = $clog2(queueDepth);
  typedef struct packed {
    logic [instructionWidth-1:0]        ins;
    logic [addressWidth-1:0]            adr;
    logic [formatWidth-1:0]             fmt;
    logic                               b64;
    logic [PidSize-1:0]                 pid;
    logic [TidSize-1:0]                 tid;
    logic [instructionCounterWidth-1:0] id;
  } entry_t;
  entry_t mem_q [queueDepth];
  entry_t out_q, out_d, in_entry;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [countWidth-1:0] count_q, count_d;
  logic [instructionCounterWidth-1:0] majid_q, majid_d;
  logic en_q, en_d, push, pop;
  // Ready looks only at the registered count, so a full FIFO stays closed even while popping.
  assign fetchReady_o = (count_q < countWidth'(queueDepth)) && !flush_i;
  assign push = fetchValid_i && fetchReady_o;
  assign pop = !flush_i && !stall_i && (count_q != '0);
  assign in_entry = '{instruction_i, instructionAddress_i, instFormat_i, is64Bit_i,
                      instructionPid_i, instructionTid_i, majid_q};
  always_comb begin
    head_d  = flush_i ? '0 : head_q + PW'(pop);
    tail_d  = flush_i ? '0 : tail_q + PW'(push);
    count_d = flush_i ? '0 : count_q + countWidth'(push) - countWidth'(pop);
    majid_d = majid_q + instructionCounterWidth'(push);
    out_d   = pop ? mem_q[head_q] : out_q;
    en_d    = flush_i ? 1'b0 : (stall_i ? en_q : pop);
  end
  always_ff @(posedge clock_i)
    if (push) mem_q[tail_q] <= in_entry;
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      majid_q <= '0;
      out_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      majid_q <= majid_d;
      out_q   <= out_d;
      en_q    <= en_d;
    end
  assign enable_o             = en_q;
  assign instFormat_o         = out_q.fmt;
  assign instruction_o        = out_q.ins;
  assign instructionAddress_o = out_q.adr;
  assign is64Bit_o            = out_q.b64;
  assign instructionPid_o     = out_q.pid;
  assign instructionTid_o     = out_q.tid;
  // Primary opcode sits in the most significant bits (big-endian bit numbering 0:5).
  assign instructionOpcode_o  = out_q.ins[instructionWidth-1 -: PrimOpcodeSize];
  assign instructionMajId_o   = out_q.id;
  assign occupancy_o          = count_q;
endmodule
